inst_legal_stage: RTL and testbench
===================================

Name: inst_legal_stage

Overview:
Registered, parametrised instruction-legality stage between IFU and IDU of the NPC core. It accepts fetched instructions over a valid/ready handshake and classifies each one against the configured ISA subset (RV32I/RV64I base, optional M, optional Zicsr, plus ecall/ebreak/mret/fence). Legal instructions pass downstream. Illegal, ecall and ebreak instructions are routed to a trap port with mcause/mtval, and the stage then blocks until the core flushes. A saturating illegal-instruction counter is kept for debug.

Parameters:
XLEN, 64, 32 or 64; when 32, all RV64-only encodings are illegal (ld, lwu, sd, OP-IMM-32, OP-32, shamt[5]=1).
EN_M, 1, 1 = mul/mulh/mulhsu/mulhu/div/divu/rem/remu (and *w forms if XLEN=64) are legal; 0 = illegal.
EN_ZICSR, 1, 1 = csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci are legal; 0 = illegal.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch packet valid
in_ready  out  1  stage can accept this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  legal instruction presented downstream
out_ready  in  1  downstream accepts
out_inst  out  32  registered instruction
out_pc  out  XLEN  registered PC
trap_valid  out  1  trap request pending
trap_ack  in  1  trap unit accepts request
trap_cause  out  4  2 = illegal, 3 = breakpoint, 11 = ecall-M
trap_tval  out  XLEN  illegal: zero-extended inst; ebreak: pc; ecall: 0
flush  in  1  core redirect; clears stage and unblocks
ill_cnt  out  CNT_W  saturating count of acknowledged illegal traps

Behaviour:
- Decided: one clock, clk; reset rst is synchronous, active-high.
- Reset: state=EMPTY. out_valid=0, trap_valid=0, ill_cnt=0, trap_cause=0, trap_tval=0, out_inst=0, out_pc=0.
- Legality classification is combinational on in_inst.
  - Field checks are exact per the RISC-V spec.
  - SYSTEM funct3=0 is legal only for the exact words ecall 0x00000073, ebreak 0x00100073, mret 0x30200073.
  - SYSTEM funct3=4 is always illegal.
  - MISC-MEM funct3=0 (fence) is legal.
  - Unlisted opcodes are illegal.
  - Shift-immediate check: funct7[6:1] when XLEN=64, funct7 when XLEN=32.
- The classification result is registered with the instruction. Latency is 1 cycle from input acceptance to out_valid or trap_valid.
- FSM states:
  - EMPTY: in_ready=1 unless flush. On accept: legal → HOLD; illegal/ecall/ebreak → TRAP.
  - HOLD: out_valid=1.
    - out_ready=1 with a new accept: load the new entry and go to HOLD or TRAP (full throughput, no bubble).
    - out_ready=1 with no input: → EMPTY.
    - out_ready=0: hold all outputs stable; in_ready=0.
  - TRAP: trap_valid=1, out_valid=0, in_ready=0. trap_ack=1 → BLOCKED; an illegal cause increments ill_cnt.
  - BLOCKED: no outputs valid, in_ready=0. Stays here until flush.
- flush: in any state, next state=EMPTY and out_valid/trap_valid drop next cycle. in_ready=0 during the flush cycle, so an input offered that cycle is not taken. flush overrides out_ready and trap_ack in the same cycle, but the ill_cnt increment from a same-cycle trap_ack still occurs.
- ill_cnt saturates at 2^CNT_W-1 and does not wrap. Only flush-independent reset clears it.
- out_inst/out_pc/trap_* change only on a load and are held otherwise.
- trap_cause/trap_tval are undefined-but-stable outside TRAP; they are zeroed at reset.

Decomposition:
- Package npc_isa_pkg holds:
  - opcode constants (LOAD, STORE, OP, OP_IMM, OP_32, OP_IMM_32, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM);
  - funct7 constants 0x00/0x01/0x20;
  - exact ecall/ebreak/mret words;
  - mcause codes;
  - the state enum.
- Sub-module inst_legal_dec: purely combinational classifier with parameters XLEN/EN_M/EN_ZICSR. Outputs legal, is_ecall, is_ebreak. The stage instantiates it once.

Test Plan:
- addi 0x00000413 with out_ready=1 → out_valid next cycle, out_inst=0x00000413; back-to-back stream with no bubble.
- mul 0x02B50533 with EN_M=0 → trap_valid, cause=2, tval=0x02B50533. Pulse trap_ack → ill_cnt=1 and state BLOCKED; in_ready=0 until flush, then 1.
- ebreak 0x00100073 at pc 0x80000010 → cause=3, tval=0x80000010. ecall → cause=11, tval=0.
- XLEN=32: ld 0x00053503 and addiw → illegal. XLEN=64: both legal. Also check slli shamt=32: legal on XLEN=64, illegal on XLEN=32.
- out_ready=0 for 5 cycles in HOLD → out_inst/out_pc stable and in_ready=0. Assert flush in TRAP with a simultaneous trap_ack → EMPTY next cycle and ill_cnt increments.
- CNT_W=2: five acknowledged illegal traps (each followed by flush) → ill_cnt=3 (saturated).

Source files
------------

// File: rtl/npc_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_isa_pkg
// Description : RISC-V encoding constants, trap causes and stage state type.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_isa_pkg;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;

  localparam logic [6:0] F7_ZERO   = 7'h00;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  localparam logic [6:0] F7_ALT    = 7'h20;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [3:0] MCAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] MCAUSE_BREAK   = 4'd3;
  localparam logic [3:0] MCAUSE_ECALL_M = 4'd11;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_TRAP    = 2'd2,
    ST_BLOCKED = 2'd3
  } stage_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_legal_dec.sv
`default_nettype none
// ============================================================================
// Module      : inst_legal_dec
// Description : Combinational legality classifier for the configured ISA.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_legal_dec
  import npc_isa_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int EN_M     = 1,
  parameter int EN_ZICSR = 1
) (
  input  logic [31:0] inst,
  output logic        legal,
  output logic        is_ecall,
  output logic        is_ebreak
);

  localparam logic RV64    = (XLEN == 64);
  localparam logic HAS_M   = (EN_M != 0);
  localparam logic HAS_CSR = (EN_ZICSR != 0);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       slli_ok;
  logic       sri_ok;

  always_comb begin
    opcode    = inst[6:0];
    funct3    = inst[14:12];
    funct7    = inst[31:25];
    is_ecall  = (inst == INST_ECALL);
    is_ebreak = (inst == INST_EBREAK);
    // On RV64 funct7[0] is shamt[5], so only the upper six bits select the op.
    if (RV64) begin
      slli_ok = (funct7[6:1] == F7_ZERO[6:1]);
      sri_ok  = (funct7[6:1] == F7_ZERO[6:1]) || (funct7[6:1] == F7_ALT[6:1]);
    end else begin
      slli_ok = (funct7 == F7_ZERO);
      sri_ok  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
    end

    legal = 1'b0;
    case (opcode)
      LUI, AUIPC, JAL: legal = 1'b1;
      JALR:            legal = (funct3 == 3'd0);
      BRANCH:          legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      LOAD: begin
        case (funct3)
          3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
          3'd3, 3'd6:                   legal = RV64;
          default:                      legal = 1'b0;
        endcase
      end
      STORE:    legal = (funct3 <= 3'd2) || ((funct3 == 3'd3) && RV64);
      OP_IMM: begin
        case (funct3)
          3'd1:    legal = slli_ok;
          3'd5:    legal = sri_ok;
          default: legal = 1'b1;
        endcase
      end
      OP: begin
        case (funct7)
          F7_ZERO:   legal = 1'b1;
          F7_ALT:    legal = (funct3 == 3'd0) || (funct3 == 3'd5);
          F7_MULDIV: legal = HAS_M;
          default:   legal = 1'b0;
        endcase
      end
      OP_IMM_32: begin
        legal = RV64 && ((funct3 == 3'd0) ||
                         ((funct3 == 3'd1) && (funct7 == F7_ZERO)) ||
                         ((funct3 == 3'd5) && ((funct7 == F7_ZERO) || (funct7 == F7_ALT))));
      end
      OP_32: begin
        case (funct7)
          F7_ZERO:   legal = RV64 && ((funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd5));
          F7_ALT:    legal = RV64 && ((funct3 == 3'd0) || (funct3 == 3'd5));
          F7_MULDIV: legal = RV64 && HAS_M && (funct3 != 3'd1) && (funct3 != 3'd2) && (funct3 != 3'd3);
          default:   legal = 1'b0;
        endcase
      end
      MISC_MEM: legal = (funct3 == 3'd0);
      SYSTEM: begin
        if (funct3 == 3'd0) begin
          legal = is_ecall || is_ebreak || (inst == INST_MRET);
        end else if (funct3 == 3'd4) begin
          legal = 1'b0;
        end else begin
          legal = HAS_CSR;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_legal_stage.sv
`default_nettype none
// ============================================================================
// Module      : inst_legal_stage
// Description : Registered IFU->IDU legality stage with trap port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_legal_stage
  import npc_isa_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int EN_M     = 1,
  parameter int EN_ZICSR = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             trap_valid,
  input  logic             trap_ack,
  output logic [3:0]       trap_cause,
  output logic [XLEN-1:0]  trap_tval,
  input  logic             flush,
  output logic [CNT_W-1:0] ill_cnt
);

  stage_state_e    state;
  stage_state_e    state_nxt;
  logic            legal;
  logic            is_ecall;
  logic            is_ebreak;
  logic            accept;
  logic            take_trap;
  logic            ack_illegal;
  logic [3:0]      cause_nxt;
  logic [XLEN-1:0] tval_nxt;

  inst_legal_dec #(
    .XLEN     (XLEN),
    .EN_M     (EN_M),
    .EN_ZICSR (EN_ZICSR)
  ) u_dec (
    .inst      (in_inst),
    .legal     (legal),
    .is_ecall  (is_ecall),
    .is_ebreak (is_ebreak)
  );

  always_comb begin
    in_ready  = 1'b0;
    state_nxt = state;
    case (state)
      ST_EMPTY: in_ready = !flush;
      ST_HOLD:  in_ready = out_ready && !flush;
      default:  in_ready = 1'b0;
    endcase

    accept    = in_valid && in_ready;
    take_trap = !legal || is_ecall || is_ebreak;

    if (flush) begin
      state_nxt = ST_EMPTY;
    end else if (accept) begin
      state_nxt = take_trap ? ST_TRAP : ST_HOLD;
    end else begin
      case (state)
        ST_HOLD: if (out_ready) state_nxt = ST_EMPTY;
        ST_TRAP: if (trap_ack)  state_nxt = ST_BLOCKED;
        default: state_nxt = state;
      endcase
    end

    if (is_ecall) begin
      cause_nxt = MCAUSE_ECALL_M;
      tval_nxt  = '0;
    end else if (is_ebreak) begin
      cause_nxt = MCAUSE_BREAK;
      tval_nxt  = in_pc;
    end else begin
      cause_nxt = MCAUSE_ILLEGAL;
      tval_nxt  = XLEN'(in_inst);
    end

    // Counted even when a flush lands in the same cycle as the acknowledge.
    ack_illegal = (state == ST_TRAP) && trap_ack && (trap_cause == MCAUSE_ILLEGAL);
  end

  assign out_valid  = (state == ST_HOLD);
  assign trap_valid = (state == ST_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      out_inst   <= '0;
      out_pc     <= '0;
      trap_cause <= '0;
      trap_tval  <= '0;
      ill_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_inst <= in_inst;
        out_pc   <= in_pc;
        if (take_trap) begin
          trap_cause <= cause_nxt;
          trap_tval  <= tval_nxt;
        end
      end
      if (ack_illegal && (ill_cnt != {CNT_W{1'b1}})) begin
        ill_cnt <= ill_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_legal_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_legal_stage
// Description : Two configurations (RV64+M+Zicsr / RV32 bare, CNT_W=2) vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_legal_stage;

  localparam int S_EMPTY = 0;
  localparam int S_HOLD  = 1;
  localparam int S_TRAP  = 2;
  localparam int S_BLK   = 3;

  logic clk = 1'b0;
  logic rst;
  logic        iv    [2];
  logic        ordy  [2];
  logic        tack  [2];
  logic        fl    [2];
  logic [31:0] iinst [2];
  logic [63:0] ipc   [2];

  logic        a_ir, a_ov, a_tv;
  logic [31:0] a_oi;
  logic [63:0] a_op, a_tt;
  logic [3:0]  a_tc;
  logic [15:0] a_cnt;
  logic        b_ir, b_ov, b_tv;
  logic [31:0] b_oi, b_op, b_tt;
  logic [3:0]  b_tc;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  int          c_xlen [2] = '{64, 32};
  bit          c_m    [2] = '{1'b1, 1'b0};
  bit          c_csr  [2] = '{1'b1, 1'b0};
  int          c_cmax [2] = '{65535, 3};
  int          m_st   [2];
  logic [31:0] m_inst [2];
  logic [63:0] m_pc   [2];
  logic [63:0] m_tval [2];
  logic [3:0]  m_cause[2];
  int          m_cnt  [2];

  initial forever #5 clk = ~clk;

  inst_legal_stage #(.XLEN(64), .EN_M(1), .EN_ZICSR(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(a_ir), .in_inst(iinst[0]),
    .in_pc(ipc[0]), .out_valid(a_ov), .out_ready(ordy[0]), .out_inst(a_oi),
    .out_pc(a_op), .trap_valid(a_tv), .trap_ack(tack[0]), .trap_cause(a_tc),
    .trap_tval(a_tt), .flush(fl[0]), .ill_cnt(a_cnt)
  );

  inst_legal_stage #(.XLEN(32), .EN_M(0), .EN_ZICSR(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(b_ir), .in_inst(iinst[1]),
    .in_pc(ipc[1][31:0]), .out_valid(b_ov), .out_ready(ordy[1]), .out_inst(b_oi),
    .out_pc(b_op), .trap_valid(b_tv), .trap_ack(tack[1]), .trap_cause(b_tc),
    .trap_tval(b_tt), .flush(fl[1]), .ill_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference legality from the ISA tables, keyed by raw opcode values.
  function automatic bit ref_legal(input logic [31:0] w, input int xl, input bit m, input bit csr);
    logic [6:0] op;
    logic [6:0] f7;
    int         f3;
    bit         r64;
    op  = w[6:0];
    f7  = w[31:25];
    f3  = int'(w[14:12]);
    r64 = (xl == 64);
    case (op)
      7'h37, 7'h17, 7'h6f: return 1'b1;
      7'h67: return f3 == 0;
      7'h63: return !(f3 inside {2, 3});
      7'h03: return (f3 inside {0, 1, 2, 4, 5}) || (r64 && (f3 inside {3, 6}));
      7'h23: return (f3 inside {0, 1, 2}) || (r64 && f3 == 3);
      7'h13: begin
        if (f3 == 1) return r64 ? (f7 >> 1) == 7'h00 : f7 == 7'h00;
        if (f3 == 5) return r64 ? ((f7 >> 1) == 7'h00 || (f7 >> 1) == 7'h10)
                                : (f7 == 7'h00 || f7 == 7'h20);
        return 1'b1;
      end
      7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {0, 5})) || (f7 == 7'h01 && m);
      7'h1b: return r64 && (f3 == 0 || (f3 == 1 && f7 == 7'h00) ||
                            (f3 == 5 && (f7 == 7'h00 || f7 == 7'h20)));
      7'h3b: return r64 && ((f7 == 7'h00 && (f3 inside {0, 1, 5})) ||
                            (f7 == 7'h20 && (f3 inside {0, 5})) ||
                            (f7 == 7'h01 && m && (f3 inside {0, 4, 5, 6, 7})));
      7'h0f: return f3 == 0;
      7'h73: begin
        if (f3 == 0) return (w == 32'h73) || (w == 32'h0010_0073) || (w == 32'h3020_0073);
        if (f3 == 4) return 1'b0;
        return csr;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [13];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h3b, 7'h1b, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};
    w = $urandom;
    case ($urandom_range(0, 15))
      0: ;
      1: w = 32'h0000_0073;
      2: w = 32'h0010_0073;
      3: w = 32'h3020_0073;
      default: begin
        w[6:0] = ops[$urandom_range(0, 12)];
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h01;
          2: w[31:25] = 7'h20;
          default: ;
        endcase
      end
    endcase
    return w;
  endfunction

  task automatic drive(input int k, input logic v, input logic [31:0] w, input logic [63:0] pc,
                       input logic r, input logic ack, input logic f);
    iv[k] = v; iinst[k] = w; ipc[k] = pc; ordy[k] = r; tack[k] = ack; fl[k] = f;
  endtask

  task automatic sample(input int k, output logic ir, output logic ov, output logic tv,
                        output logic [31:0] oi, output logic [63:0] op, output logic [63:0] tt,
                        output logic [3:0] tc, output logic [15:0] cnt);
    if (k == 0) begin
      ir = a_ir; ov = a_ov; tv = a_tv; oi = a_oi; op = a_op; tt = a_tt; tc = a_tc; cnt = a_cnt;
    end else begin
      ir = b_ir; ov = b_ov; tv = b_tv; oi = b_oi; op = {32'h0, b_op}; tt = {32'h0, b_tt};
      tc = b_tc; cnt = {14'h0, b_cnt};
    end
  endtask

  // Compare both DUTs against the model with current inputs, then advance one clock.
  task automatic step();
    logic ir, ov, tv;
    logic [31:0] oi;
    logic [63:0] op, tt, mask;
    logic [3:0] tc;
    logic [15:0] cnt;
    bit rdy, acc, lg, ec, eb;
    #1;
    for (int k = 0; k < 2; k++) begin
      sample(k, ir, ov, tv, oi, op, tt, tc, cnt);
      rdy = !fl[k] && (m_st[k] == S_EMPTY || (m_st[k] == S_HOLD && ordy[k]));
      check($sformatf("in_ready[%0d]", k), 64'(ir), 64'(rdy));
      check($sformatf("out_valid[%0d]", k), 64'(ov), 64'(m_st[k] == S_HOLD));
      check($sformatf("trap_valid[%0d]", k), 64'(tv), 64'(m_st[k] == S_TRAP));
      check($sformatf("ill_cnt[%0d]", k), 64'(cnt), 64'(m_cnt[k]));
      if (m_st[k] == S_HOLD) begin
        check($sformatf("out_inst[%0d]", k), 64'(oi), 64'(m_inst[k]));
        check($sformatf("out_pc[%0d]", k), op, m_pc[k]);
      end
      if (m_st[k] == S_TRAP) begin
        check($sformatf("trap_cause[%0d]", k), 64'(tc), 64'(m_cause[k]));
        check($sformatf("trap_tval[%0d]", k), tt, m_tval[k]);
      end

      mask = (c_xlen[k] == 64) ? '1 : 64'hFFFF_FFFF;
      acc  = iv[k] && rdy;
      if (m_st[k] == S_TRAP && tack[k] && m_cause[k] == 4'd2 && m_cnt[k] < c_cmax[k])
        m_cnt[k]++;
      if (fl[k]) begin
        m_st[k] = S_EMPTY;
      end else if (acc) begin
        lg = ref_legal(iinst[k], c_xlen[k], c_m[k], c_csr[k]);
        ec = (iinst[k] == 32'h73);
        eb = (iinst[k] == 32'h0010_0073);
        m_inst[k] = iinst[k];
        m_pc[k]   = ipc[k] & mask;
        if (!lg || ec || eb) begin
          m_st[k]    = S_TRAP;
          m_cause[k] = ec ? 4'd11 : (eb ? 4'd3 : 4'd2);
          m_tval[k]  = ec ? 64'h0 : (eb ? (ipc[k] & mask) : {32'h0, iinst[k]});
        end else begin
          m_st[k] = S_HOLD;
        end
      end else if (m_st[k] == S_HOLD && ordy[k]) begin
        m_st[k] = S_EMPTY;
      end else if (m_st[k] == S_TRAP && tack[k]) begin
        m_st[k] = S_BLK;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      m_st[k] = S_EMPTY; m_inst[k] = '0; m_pc[k] = '0; m_tval[k] = '0; m_cause[k] = '0; m_cnt[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready_a", 64'(a_ir), 64'd1);
    check("rst_out_valid_a", 64'(a_ov), 64'd0);
    check("rst_trap_valid_a", 64'(a_tv), 64'd0);
    check("rst_out_inst_a", 64'(a_oi), 64'd0);
    check("rst_out_pc_a", a_op, 64'd0);
    check("rst_trap_cause_a", 64'(a_tc), 64'd0);
    check("rst_trap_tval_a", a_tt, 64'd0);
    check("rst_ill_cnt_a", 64'(a_cnt), 64'd0);
    check("rst_trap_valid_b", 64'(b_tv), 64'd0);
    check("rst_ill_cnt_b", 64'(b_cnt), 64'd0);
    @(negedge clk);

    // addi on A; mul on B (EN_M=0) traps as illegal
    drive(0, 1'b1, 32'h0000_0413, 64'h1000, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h02B5_0533, 64'h2000, 1'b1, 1'b0, 1'b0);
    step();
    check("addi_valid", 64'(a_ov), 64'd1);
    check("addi_inst", 64'(a_oi), 64'h0000_0413);
    check("mul_trap", 64'(b_tv), 64'd1);
    check("mul_cause", 64'(b_tc), 64'd2);
    check("mul_tval", 64'(b_tt), 64'h02B5_0533);

    // back-to-back ld on A (legal on RV64); ack on B
    drive(0, 1'b1, 32'h0005_3503, 64'h1004, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h0000_0413, 64'h2004, 1'b1, 1'b1, 1'b0);
    step();
    check("ld64_inst", 64'(a_oi), 64'h0005_3503);
    check("ld64_valid", 64'(a_ov), 64'd1);
    check("ack_cnt1", 64'(b_cnt), 64'd1);
    check("ack_trap_drop", 64'(b_tv), 64'd0);

    drive(0, 1'b1, 32'h0010_0073, 64'h8000_0010, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h0000_0413, 64'h2008, 1'b1, 1'b0, 1'b0);
    step();
    check("ebreak_cause", 64'(a_tc), 64'd3);
    check("ebreak_tval", a_tt, 64'h8000_0010);
    check("blocked_ready", 64'(b_ir), 64'd0);

    drive(0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 1'b1);
    drive(1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    step();

    // ecall on A; ld on B (RV64-only, illegal on RV32)
    drive(0, 1'b1, 32'h0000_0073, 64'h123, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h0005_3503, 64'h3000, 1'b1, 1'b0, 1'b0);
    step();
    check("ecall_cause", 64'(a_tc), 64'd11);
    check("ecall_tval", a_tt, 64'd0);
    check("ld32_cause", 64'(b_tc), 64'd2);
    check("ld32_tval", 64'(b_tt), 64'h0005_3503);

    // flush with a simultaneous ack still counts the illegal trap
    drive(0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    drive(1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 1'b1);
    step();
    check("flush_ack_cnt", 64'(b_cnt), 64'd2);
    check("flush_ack_trap", 64'(b_tv), 64'd0);

    // addiw held on A with out_ready low; slli shamt=32 on RV32 is illegal
    drive(0, 1'b1, 32'h0015_051B, 64'h1100, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h0205_1513, 64'h3100, 1'b1, 1'b0, 1'b0);
    step();
    check("addiw_inst", 64'(a_oi), 64'h0015_051B);
    check("slli32_tval", 64'(b_tt), 64'h0205_1513);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, $urandom, 64'($urandom), 1'b0, 1'b0, 1'b0);
      drive(1, 1'b1, $urandom, 64'($urandom), 1'b1, 1'b0, 1'b0);
      step();
    end
    check("hold_inst", 64'(a_oi), 64'h0015_051B);
    check("hold_pc", a_op, 64'h1100);
    check("hold_ready", 64'(a_ir), 64'd0);

    drive(0, 1'b1, 32'h0205_1513, 64'h1200, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 1'b1);
    step();
    check("slli64_inst", 64'(a_oi), 64'h0205_1513);
    check("slli64_valid", 64'(a_ov), 64'd1);
    check("cnt3", 64'(b_cnt), 64'd3);

    drive(0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h0015_051B, 64'h3200, 1'b1, 1'b0, 1'b0);
    step();
    check("addiw32_cause", 64'(b_tc), 64'd2);
    drive(1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 1'b1);
    step();
    check("cnt_saturated", 64'(b_cnt), 64'd3);

    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, ($urandom_range(0, 9) < 7), rand_inst(),
              (k == 0) ? {$urandom, $urandom} : {32'h0, $urandom},
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
              (m_st[k] == S_BLK) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
